multicycle_ctrl: RTL

//  Multi-cycle control FSM sequencing the RV32I datapath (PC, instruction memory, decoder, register file, ALU, data memory).

---
 rtl/rv32i_pkg.sv | 44 ++++
 rtl/ctrl_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcode, FSM state and mux-select encodings for the control path and decoder.
//   Exports: OP_* opcodes, state_t, PC_* (pc_sel) and WB_* (wb_sel) codes,
//            is_legal() opcode check, uses_imm() ALU operand-B select.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                          OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        return op inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive memory wait cycles and flags a bus timeout.
//   clk      in  clock
//   reset    in  synchronous active-low reset
//   clr      in  clear the wait count
//   en       in  a request is outstanding and ready is low this cycle
//   expired  out this wait cycle is the TIMEOUT-th one (TIMEOUT=0 never expires)
module ctrl_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= r_cnt + CW'(1);
    end

    // Fires on the cycle whose increment would reach TIMEOUT; a ready in that cycle drops en and wins.
    assign expired = (TIMEOUT != 0) && en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
//   clk, reset(active-low sync)      clocking
//   opcode, branch_cond               decoder opcode (sampled in DECODE), ALU compare (EXEC)
//   imem_ready, dmem_ready            memory handshakes, honoured only in FETCH / MEM
//   imem_req, ir_we                   fetch request, IR load pulse
//   dmem_req, dmem_we                 data request, write qualifier
//   pc_we, pc_sel                     PC update strobe (one per retired instr) and source
//   reg_we, wb_sel, alu_src_b         register write-back and ALU operand select
//   state, retired                    debug state, retired-instruction count
//   halted, illegal_instr, bus_fault  sticky stop status
module multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int RET_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_cond,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired,
    output logic             halted,
    output logic             illegal_instr,
    output logic             bus_fault
);

    state_t           r_state;
    logic [6:0]       r_op;
    logic [RET_W-1:0] r_retired;
    logic             r_illegal;
    logic             r_bus_fault;
    logic             w_wait_en;
    logic             w_expired;

    // The FSM only lingers in FETCH/MEM while waiting, so counting consecutive
    // waits equals counting waits since entry.
    assign w_wait_en = (r_state == ST_FETCH && !imem_ready) || (r_state == ST_MEM && !dmem_ready);

    ctrl_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!w_wait_en),
        .en      (w_wait_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_op        <= '0;
            r_retired   <= '0;
            r_illegal   <= 1'b0;
            r_bus_fault <= 1'b0;
        end else begin
            if (pc_we)
                r_retired <= r_retired + RET_W'(1);
            case (r_state)
                ST_FETCH:
                    if (imem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_expired) begin
                        r_state     <= ST_HALT;
                        r_bus_fault <= 1'b1;
                    end
                ST_DECODE: begin
                    r_op <= opcode;
                    if (opcode == OP_SYSTEM) begin
                        r_state <= ST_HALT;
                    end else if (!is_legal(opcode)) begin
                        r_state   <= ST_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC:
                    r_state <= (r_op == OP_BRANCH || r_op == OP_FENCE) ? ST_FETCH :
                               (r_op == OP_LOAD || r_op == OP_STORE)   ? ST_MEM : ST_WB;
                ST_MEM:
                    if (dmem_ready) begin
                        r_state <= (r_op == OP_STORE) ? ST_FETCH : ST_WB;
                    end else if (w_expired) begin
                        r_state     <= ST_HALT;
                        r_bus_fault <= 1'b1;
                    end
                ST_WB:
                    r_state <= ST_FETCH;
                default:
                    r_state <= ST_HALT;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_b = 1'b0;
        if (reset) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_EXEC: begin
                    alu_src_b = uses_imm(r_op);
                    pc_we     = (r_op == OP_BRANCH) || (r_op == OP_FENCE);
                    pc_sel    = (r_op == OP_BRANCH && branch_cond) ? PC_IMM : PC_PLUS4;
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (r_op == OP_STORE);
                    pc_we    = dmem_ready && (r_op == OP_STORE);
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    wb_sel = (r_op == OP_LOAD) ? WB_LOAD :
                             (r_op == OP_JAL || r_op == OP_JALR) ? WB_PC4 : WB_ALU;
                    pc_sel = (r_op == OP_JAL) ? PC_IMM : (r_op == OP_JALR) ? PC_JALR : PC_PLUS4;
                end
                default: ;
            endcase
        end
    end

    assign state         = r_state;
    assign retired       = r_retired;
    assign halted        = (r_state == ST_HALT);
    assign illegal_instr = r_illegal;
    assign bus_fault     = r_bus_fault;

endmodule
